// File: rtl/mul_issue_ctrl_if.sv
// Bundles the core request/response channel and the multiplier_top control/result wires.
// slave: the issue controller; master: the core plus multiplier environment.
interface mul_issue_ctrl_if;
  logic        req_valid;
  logic        req_ready;
  logic [6:0]  opcode;
  logic [2:0]  funct3;
  logic [6:0]  funct7;
  logic [31:0] rs1;
  logic [31:0] rs2;
  logic [4:0]  rd;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_data;
  logic [4:0]  rsp_rd;
  logic        rsp_err;
  logic        mul_en;
  logic [31:0] mul_op_a;
  logic [31:0] mul_op_b;
  logic        mul_signed_a;
  logic        mul_signed_b;
  logic        mul_upper;
  logic [31:0] mul_result;
  logic        mul_done;

  modport slave (
    input  req_valid, opcode, funct3, funct7, rs1, rs2, rd, rsp_ready, mul_result, mul_done,
    output req_ready, rsp_valid, rsp_data, rsp_rd, rsp_err,
    output mul_en, mul_op_a, mul_op_b, mul_signed_a, mul_signed_b, mul_upper
  );

  modport master (
    output req_valid, opcode, funct3, funct7, rs1, rs2, rd, rsp_ready, mul_result, mul_done,
    input  req_ready, rsp_valid, rsp_data, rsp_rd, rsp_err,
    input  mul_en, mul_op_a, mul_op_b, mul_signed_a, mul_signed_b, mul_upper
  );
endinterface

// File: rtl/mul_issue_ctrl.sv
// RV32M issue controller: accepts one instruction, drives multiplier_top until done or
// timeout, then returns result/rd/err over a valid/ready response channel.
module mul_issue_ctrl #(
  parameter int unsigned TIMEOUT_CYC = 16,
  parameter int unsigned CNT_W       = 5
) (
  input  logic              clk_i,
  input  logic              rst_i,
  mul_issue_ctrl_if.slave   bus
);

  localparam logic [1:0] StIdle = 2'd0;
  localparam logic [1:0] StWait = 2'd1;
  localparam logic [1:0] StResp = 2'd2;

  logic [1:0]       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [31:0]      op_a_q, op_a_d;
  logic [31:0]      op_b_q, op_b_d;
  logic             sa_q, sa_d;
  logic             sb_q, sb_d;
  logic             up_q, up_d;
  logic [31:0]      rsp_data_q, rsp_data_d;
  logic [4:0]       rsp_rd_q, rsp_rd_d;
  logic             rsp_err_q, rsp_err_d;

  logic legal;

  assign legal = (bus.opcode == 7'b0110011) && (bus.funct7 == 7'b0000001) && !bus.funct3[2];

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    op_a_d     = op_a_q;
    op_b_d     = op_b_q;
    sa_d       = sa_q;
    sb_d       = sb_q;
    up_d       = up_q;
    rsp_data_d = rsp_data_q;
    rsp_rd_d   = rsp_rd_q;
    rsp_err_d  = rsp_err_q;

    case (state_q)
      StIdle: begin
        if (bus.req_valid) begin
          rsp_rd_d = bus.rd;
          cnt_d    = '0;
          if (legal) begin
            // Operands only move on legal ops so the multiplier inputs stay quiet otherwise.
            op_a_d  = bus.rs1;
            op_b_d  = bus.rs2;
            sa_d    = (bus.funct3[1:0] != 2'b11);
            sb_d    = !bus.funct3[1];
            up_d    = (bus.funct3[1:0] != 2'b00);
            state_d = StWait;
          end else begin
            rsp_data_d = '0;
            rsp_err_d  = 1'b1;
            state_d    = StResp;
          end
        end
      end
      StWait: begin
        cnt_d = cnt_q + 1'b1;
        if (bus.mul_done) begin
          rsp_data_d = bus.mul_result;
          rsp_err_d  = 1'b0;
          state_d    = StResp;
        end else if (cnt_q == CNT_W'(TIMEOUT_CYC - 1)) begin
          rsp_data_d = '0;
          rsp_err_d  = 1'b1;
          state_d    = StResp;
        end
      end
      StResp: begin
        if (bus.rsp_ready) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q    <= StIdle;
      cnt_q      <= '0;
      op_a_q     <= '0;
      op_b_q     <= '0;
      sa_q       <= 1'b0;
      sb_q       <= 1'b0;
      up_q       <= 1'b0;
      rsp_data_q <= '0;
      rsp_rd_q   <= '0;
      rsp_err_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      op_a_q     <= op_a_d;
      op_b_q     <= op_b_d;
      sa_q       <= sa_d;
      sb_q       <= sb_d;
      up_q       <= up_d;
      rsp_data_q <= rsp_data_d;
      rsp_rd_q   <= rsp_rd_d;
      rsp_err_q  <= rsp_err_d;
    end
  end

  // Ready is masked by reset so every output reads 0 while reset is held.
  assign bus.req_ready    = (state_q == StIdle) && !rst_i;
  assign bus.rsp_valid    = (state_q == StResp);
  assign bus.rsp_data     = rsp_data_q;
  assign bus.rsp_rd       = rsp_rd_q;
  assign bus.rsp_err      = rsp_err_q;
  assign bus.mul_en       = (state_q == StWait);
  assign bus.mul_op_a     = op_a_q;
  assign bus.mul_op_b     = op_b_q;
  assign bus.mul_signed_a = sa_q;
  assign bus.mul_signed_b = sb_q;
  assign bus.mul_upper    = up_q;

endmodule
